// File: rtl/serial_slave_port_if.sv
// Serial bus bundle between the bus master and one slave endpoint.
// The master drives the control frame and write bits; the slave answers with ready, read bits and status.
interface serial_slave_port_if;
  logic control;
  logic wrD;
  logic valid;
  logic last;
  logic rD;
  logic ready;
  logic busy;
  logic frameErr;

  modport master (
    output control, wrD, valid, last,
    input  rD, ready, busy, frameErr
  );

  modport slave (
    input  control, wrD, valid, last,
    output rD, ready, busy, frameErr
  );
endinterface

// File: rtl/serial_slave_port.sv
// Slave endpoint of the serial bus: decodes the control frame and runs single or burst
// word transfers between the serial data lines and a local word memory.
module serial_slave_port #(
  parameter int         MEMORY_DEPTH = 4096,
  parameter int         DATA_WIDTH   = 16,
  parameter logic [1:0] SLAVE_ID     = 2'b00
) (
  input logic          clk,
  input logic          rstN,
  serial_slave_port_if.slave bus
);
  localparam int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH);
  localparam int HDR_BITS      = 4 + ADDRESS_WIDTH;
  localparam int CNT_MAX       = (HDR_BITS > DATA_WIDTH) ? HDR_BITS : DATA_WIDTH;
  localparam int CNT_WIDTH     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_WIDTH-1:0]     HDR_END   = CNT_WIDTH'(HDR_BITS - 1);
  localparam logic [CNT_WIDTH-1:0]     WORD_END  = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, IGNORE, WR_DATA, RD_FETCH, RD_DATA, DONE
  } state_t;

  state_t state, state_next;

  logic [1:0]               window;
  logic [HDR_BITS-2:0]      hdr_shift;
  logic [CNT_WIDTH-1:0]     bit_cnt;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [ADDRESS_WIDTH-1:0] addr_inc;
  logic                     burst;
  logic                     word_written;
  logic                     frame_err;
  logic [DATA_WIDTH-1:0]    word;
  logic [DATA_WIDTH-1:0]    mem [MEMORY_DEPTH];

  logic [HDR_BITS-1:0]      hdr_full;
  logic [DATA_WIDTH-1:0]    word_in;
  logic                     start_seen;
  logic                     hdr_end;
  logic                     word_end;
  logic                     mem_we;
  logic                     err_pulse;
  logic                     ready_c;
  logic                     busy_c;
  logic                     rd_c;

  assign hdr_full   = {hdr_shift, bus.control};
  assign word_in    = {word[DATA_WIDTH-2:0], bus.wrD};
  assign start_seen = ({window, bus.control} == 3'b111);
  assign hdr_end    = (bit_cnt == HDR_END);
  assign word_end   = (bit_cnt == WORD_END);
  assign addr_inc   = (addr == ADDR_LAST) ? '0 : addr + ADDRESS_WIDTH'(1);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_c    = 1'b0;
    busy_c     = 1'b0;
    rd_c       = 1'b0;
    mem_we     = 1'b0;
    err_pulse  = 1'b0;
    case (state)
      IDLE: if (start_seen) state_next = HDR;
      HDR: begin
        if (hdr_end) begin
          if (hdr_full[HDR_BITS-1 -: 2] != SLAVE_ID) state_next = IGNORE;
          else if (hdr_full[HDR_BITS-3])              state_next = WR_DATA;
          else                                        state_next = RD_FETCH;
        end
      end
      IGNORE: if (bus.valid && bus.last) state_next = IDLE;
      WR_DATA: begin
        ready_c = 1'b1;
        busy_c  = 1'b1;
        if (bus.valid) begin
          // A non-burst transfer commits only its first complete word.
          mem_we = word_end && (burst || !word_written);
          if (bus.last) begin
            state_next = DONE;
            err_pulse  = !word_end;
          end
        end
      end
      RD_FETCH: begin
        busy_c     = 1'b1;
        state_next = RD_DATA;
      end
      RD_DATA: begin
        ready_c = 1'b1;
        busy_c  = 1'b1;
        rd_c    = word[DATA_WIDTH-1];
        if (bus.valid) begin
          if (bus.last) begin
            state_next = DONE;
            err_pulse  = !word_end;
          end else if (word_end && burst) begin
            state_next = RD_FETCH;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      window       <= '0;
      hdr_shift    <= '0;
      bit_cnt      <= '0;
      addr         <= '0;
      burst        <= 1'b0;
      word_written <= 1'b0;
      frame_err    <= 1'b0;
      word         <= '0;
    end else begin
      frame_err <= err_pulse;
      case (state)
        IDLE: begin
          window  <= start_seen ? 2'b00 : {window[0], bus.control};
          bit_cnt <= '0;
        end
        HDR: begin
          hdr_shift <= hdr_full[HDR_BITS-2:0];
          if (hdr_end) begin
            bit_cnt      <= '0;
            addr         <= hdr_full[ADDRESS_WIDTH-1:0];
            burst        <= hdr_full[ADDRESS_WIDTH];
            word_written <= 1'b0;
            word         <= '0;
          end else begin
            bit_cnt <= bit_cnt + CNT_WIDTH'(1);
          end
        end
        WR_DATA: begin
          if (bus.valid) begin
            word <= word_in;
            if (word_end) begin
              bit_cnt      <= '0;
              word_written <= 1'b1;
              if (burst) addr <= addr_inc;
            end else begin
              bit_cnt <= bit_cnt + CNT_WIDTH'(1);
            end
          end
        end
        RD_FETCH: word <= mem[addr];
        RD_DATA: begin
          // Rotating restores the word after a full pass, so a non-burst read can repeat it.
          if (bus.valid) begin
            word <= {word[DATA_WIDTH-2:0], word[DATA_WIDTH-1]};
            if (word_end) begin
              bit_cnt <= '0;
              if (burst) addr <= addr_inc;
            end else begin
              bit_cnt <= bit_cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= word_in;
  end

  assign bus.ready    = ready_c;
  assign bus.busy     = busy_c;
  assign bus.rD       = rd_c;
  assign bus.frameErr = frame_err;
endmodule
